// File: rtl/nios_sd_loader_lcd_sequencer_pkg.sv
// Shared definitions for the LCD byte sequencer: FSM encoding, register map,
// status bit positions and the clear/home opcode decode.
package nios_sd_loader_lcd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_IRQ    = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_LEVEL = 1;
  localparam int STAT_OVF   = 4;

  // Upper seven opcode bits of clear display (0x01) and return home (0x02/0x03)
  localparam logic [6:0] OPC_CLEAR_HI = 7'b0000000;
  localparam logic [6:0] OPC_HOME_HI  = 7'b0000001;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] code);
    return (rs == 1'b0) && ((code[7:1] == OPC_CLEAR_HI) || (code[7:1] == OPC_HOME_HI));
  endfunction

endpackage

// File: rtl/nios_sd_loader_lcd_sequencer_fifo.sv
// Small synchronous FIFO holding {rs, byte} entries for the LCD sequencer.
// A push while full is accepted only when a pop happens in the same cycle.
module lcd_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against occupancy
  always_comb begin
    do_pop_s  = pop && (level_r != {LW{1'b0}});
    do_push_s = push && ((level_r != LW'(DEPTH)) || do_pop_s);
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (level_r == LW'(DEPTH));
  assign empty = (level_r == {LW{1'b0}});
  assign level = level_r;

endmodule

// File: rtl/nios_sd_loader_lcd_sequencer.sv
// Avalon-MM LCD sequencer: queues HD44780 bytes and times RS/data/E on the bus.
// Optional interrupt on idle is built when LCD_SEQ_IRQ_EN is defined.
module nios_sd_loader_lcd_sequencer
  import nios_sd_loader_lcd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        irq
);

  localparam int CW = $clog2(T_EXEC_LONG) + 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);

  lcd_state_e    state_r;
  logic [CW-1:0] cnt_r;
  logic          long_r;
  logic          overflow_r;

  logic          wr_s;
  logic          push_s;
  logic          pop_s;
  logic          clr_ovf_s;
  logic          busy_s;
  logic [8:0]    fifo_din_s;
  logic [8:0]    fifo_dout_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [LW-1:0] fifo_level_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  // Avalon write decode and sequencer handshake
  always_comb begin
    wr_s       = chipselect && !write_n;
    push_s     = wr_s && ((address == ADDR_DATA) || (address == ADDR_CMD));
    clr_ovf_s  = wr_s && (address == ADDR_STATUS);
    fifo_din_s = {(address == ADDR_DATA), writedata[7:0]};
    pop_s      = (state_r == ST_IDLE) && !fifo_empty_s;
    busy_s     = (state_r != ST_IDLE) || !fifo_empty_s;
  end

  lcd_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .din     (fifo_din_s),
    .pop     (pop_s),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_s)
  );

  // Sticky overflow: set by a push the full queue cannot absorb
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (clr_ovf_s) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Bus timing FSM; data and RS only change on the IDLE pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      long_r   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            lcd_data <= fifo_dout_s[7:0];
            lcd_rs   <= fifo_dout_s[8];
            long_r   <= is_long_cmd(fifo_dout_s[8], fifo_dout_s[7:0]);
            cnt_r    <= LD_SETUP;
            state_r  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_r == {CW{1'b0}}) begin
            lcd_en  <= 1'b1;
            cnt_r   <= LD_PULSE;
            state_r <= ST_PULSE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_r == {CW{1'b0}}) begin
            lcd_en  <= 1'b0;
            cnt_r   <= LD_HOLD;
            state_r <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_r == {CW{1'b0}}) begin
            cnt_r   <= long_r ? LD_LONG : LD_EXEC;
            state_r <= ST_WAIT;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          lcd_en  <= 1'b0;
          cnt_r   <= {CW{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LCD_SEQ_IRQ_EN
  logic irq_en_r;

  // Interrupt enable register and registered idle interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_r <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_s && (address == ADDR_IRQ)) begin
        irq_en_r <= writedata[0];
      end
      irq <= irq_en_r && !busy_s;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Zero-wait-state read mux
  always_comb begin
    rdata_s = 32'd0;
    case (address)
      ADDR_STATUS: begin
        rdata_s[STAT_BUSY]            = busy_s;
        rdata_s[STAT_LEVEL +: LW]     = fifo_level_s;
        rdata_s[STAT_OVF]             = overflow_r;
      end
`ifdef LCD_SEQ_IRQ_EN
      ADDR_IRQ: begin
        rdata_s[0] = irq_en_r;
      end
`endif
      default: begin
        rdata_s = 32'd0;
      end
    endcase
  end

  assign readdata = rdata_s;
  assign lcd_rw   = 1'b0;
  assign unused_s = ^writedata[31:8];

endmodule

// File: doc/nios_sd_loader_lcd_sequencer.md
Name: nios_sd_loader_lcd_sequencer

Overview:
- Avalon-MM slave that queues HD44780-style LCD command/data bytes and sequences the physical LCD bus.
- Drives the 8-bit data bus, RS, RW and E with programmed setup, pulse, hold and execution timing.
- Replaces direct CPU bit-banging of the LCD data PIO; Nios software only pushes bytes and polls status.

Parameters:
- FIFO_DEPTH, 4: entry count of the byte queue; power of two, at least 2.
- T_SETUP, 2: clocks RS/data are stable before E rises.
- T_PULSE, 12: clocks E is held high.
- T_HOLD, 2: clocks data/RS are held after E falls.
- T_EXEC, 2000: post-write wait in clocks for normal commands/data (40 us at 50 MHz).
- T_EXEC_LONG, 82000: post-write wait for clear/home (1.64 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational, zero wait states
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  register select: 1 = data, 0 = command
- lcd_rw  out  1  read/write select; tied to 0 (write-only)
- lcd_en  out  1  LCD enable strobe
- irq  out  1  interrupt; see Optional Feature

Behaviour:
- Registers:
  - addr0 write: push {RS=1, writedata[7:0]}.
  - addr1 write: push {RS=0, writedata[7:0]}.
  - addr2 read: {overflow[4], level[3:1], busy[0]}, upper bits 0; level width is $clog2(FIFO_DEPTH)+1.
  - addr2 write: any value clears overflow.
  - addr3: see Optional Feature.
  - Reads of addr0/1 return 0.
- busy = FSM not in IDLE, or FIFO not empty.
- FIFO:
  - A push when full is dropped and sets sticky overflow.
  - Simultaneous push and pop is legal when full or empty; level is unchanged when full.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
  - IDLE: if FIFO is non-empty, pop the head into the output registers (lcd_data, lcd_rs) in the same cycle, load cnt = T_SETUP-1, and go to SETUP.
  - SETUP: on cnt==0, lcd_en<=1 and cnt=T_PULSE-1; go to PULSE.
  - PULSE: on cnt==0, lcd_en<=0 and cnt=T_HOLD-1; go to HOLD.
  - HOLD: on cnt==0, cnt=(long ? T_EXEC_LONG : T_EXEC)-1; go to WAIT.
  - WAIT: on cnt==0, go to IDLE.
  - Otherwise, cnt decrements each clock.
- long is true when RS=0 and byte[7:1]==7'b0000000 or 7'b0000001 (clear/home).
- lcd_data and lcd_rs change only on the IDLE pop, i.e. never while E is high or during hold.
- Latency: a write to an empty, idle block raises E at clock 1+T_SETUP after the write cycle.
- Counter width is $clog2(T_EXEC_LONG)+1, sized for the largest timing parameter.
- Reset values:
  - lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, irq=0.
  - FIFO empty, overflow=0, FSM=IDLE, cnt=0.
  - Reset mid-transfer drops E immediately and flushes the queue.

Optional Feature:
- Macro: LCD_SEQ_IRQ_EN.
- Defined:
  - addr3 bit0 = irq_enable (R/W, reset 0).
  - irq is registered: 1 when irq_enable && !busy.
  - irq clears when a push makes busy=1.
- Undefined: irq is tied to 0, addr3 reads 0, and writes to addr3 are ignored.

Decomposition:
- Shared package: FSM state encoding, register address constants (ADDR_DATA=0, ADDR_CMD=1, ADDR_STATUS=2, ADDR_IRQ=3), status bit positions, and the clear/home opcode constants.
- Sub-module: lcd_seq_fifo, a 9-bit-wide synchronous FIFO with full, empty and level outputs.

Test Plan:
- Write 0x41 to addr0 with T_SETUP=2, T_PULSE=12 -> lcd_rs=1 and lcd_data=0x41 one clock later; E high for exactly 12 clocks; busy drops 2+12+2+2000 clocks after the pop.
- Write 0x01 to addr1 -> lcd_rs=0; WAIT lasts 82000 clocks. Write 0x38 -> WAIT lasts 2000 clocks.
- Burst 6 writes with FIFO_DEPTH=4 while the first is in flight -> 5 transfers reach the bus in order, 1 is dropped, status bit4=1. Write addr2 -> bit4=0.
- Assert reset_n low while lcd_en=1 -> lcd_en=0 asynchronously; after release, status reads 0 and no further E pulses occur.
- Push while popping with the FIFO full -> level stays 4 and no overflow is flagged.
- With LCD_SEQ_IRQ_EN: set addr3=1, write one byte -> irq=0 while busy; irq=1 one clock after busy falls.
